calc_seq: RTL and testbench
===========================

CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 Parameter EXEC_WAIT, default 1, is the number of cycles calc_en is held high before calc_total is sampled (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 key_valid  input  1  key event qualifier; one event per cycle when high.
REQ-005 key_type  input  2  00 digit, 01 operator, 10 equals, 11 clear.
REQ-006 key_data  input  4  digit value (0..15) for a digit key; operator code in bits [1:0] for an operator key (00 add, 01 sub, 10 mul, 11 div); ignored otherwise.
REQ-007 calc_total  input  8  result returned by the downstream calc stage.
REQ-008 calc_en  output  1  enable to the calc stage.
REQ-009 calc_in1  output  4  operand A to the calc stage.
REQ-010 calc_in2  output  4  operand B to the calc stage.
REQ-011 calc_ops  output  2  operator to the calc stage.
REQ-012 result  output  8  last captured result.
REQ-013 result_valid  output  1  one-cycle pulse when result updates.
REQ-014 busy  output  1  high while in S_EXEC.
REQ-015 err  output  1  sticky divide-by-zero flag.

Function
REQ-016 The FSM states SHALL be S_A (entering A), S_B (entering B), S_EXEC (calc running) and S_DONE (result held).
REQ-017 calc_in1, calc_in2 and calc_ops SHALL be driven directly from registered A, B and OP, with no combinational path from key inputs.
REQ-018 In S_A, a digit key SHALL load A=key_data, overwriting any earlier digit, and remain in S_A.
REQ-019 In S_A, an operator key SHALL load OP=key_data[1:0], clear B to 0 and go to S_B; A keeps its value (0 if no digit was entered).
REQ-020 In S_A, an equals key SHALL be ignored.
REQ-021 In S_B, a digit key SHALL load B=key_data; an operator key SHALL replace OP; both remain in S_B.
REQ-022 In S_B, an equals key with OP=11 and B=0 SHALL set err=1, set result=8'hFF, pulse result_valid on the next cycle and go to S_DONE without asserting calc_en.
REQ-023 In S_B, any other equals key SHALL go to S_EXEC.
REQ-024 In S_EXEC, calc_en SHALL be 1 for exactly EXEC_WAIT consecutive cycles, busy SHALL be 1 and all key events SHALL be ignored, including clear.
REQ-025 On the last S_EXEC cycle, result SHALL load calc_total; result_valid SHALL pulse high on the following cycle, coincident with entry to S_DONE; calc_en SHALL drop in that same cycle.
REQ-026 In S_DONE, a digit key SHALL load A=key_data, clear B, OP and err, and go to S_A.
REQ-027 In S_DONE, an operator key SHALL chain: A=result[3:0] (truncated), OP=key_data[1:0], B=0, err cleared, go to S_B.
REQ-028 In S_DONE, an equals key SHALL be ignored.
REQ-029 In S_A, S_B or S_DONE, a clear key SHALL zero A, B, OP, result and err and go to S_A; result_valid SHALL NOT pulse.
REQ-030 Key inputs SHALL be ignored whenever key_valid=0.
REQ-031 result SHALL hold its value between updates; err SHALL stay set until a clear, a digit key or an operator key is accepted in S_DONE, or reset.
REQ-032 The calc stage SHALL be treated as combinational; the block SHALL NOT reinterpret calc_total (subtraction underflow is passed through as returned).

Reset
REQ-033 rst=1 SHALL force S_A, with A=B=OP=0, result=0, result_valid=0, calc_en=0, busy=0 and err=0 on the next clk edge.
REQ-034 rst SHALL take priority over every key event and SHALL abort S_EXEC immediately, with no result capture and no result_valid pulse.

Verification
REQ-035 Keys 5, op 00, 7, equals with a calc model -> calc_en high for 1 cycle with in1=5, in2=7, ops=00; result=12 and a 1-cycle result_valid pulse.
REQ-036 Keys 12, op 11, 0, equals -> calc_en never asserted; err=1, result=8'hFF, one result_valid pulse; then digit 3 -> err=0, state S_A.
REQ-037 Keys 4, op 10, 6, equals, then op 00, 9, equals -> first result=24; chained A=24[3:0]=8, second result=17.
REQ-038 EXEC_WAIT=3, keys 8, op 01, 3, equals, with clear pulsed during S_EXEC -> busy=1 for 3 cycles, clear ignored, result=5.
REQ-039 rst asserted in the middle of S_EXEC -> next cycle all outputs 0, no result_valid pulse; a subsequent equals key is ignored in S_A.
REQ-040 Digit 9, then digit 2 in S_A, op 00, equals -> in1=2, in2=0, result=2.

Source files
------------

// File: rtl/calc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : calc_seq
//  Purpose  : Key-driven sequencer that collects operand A, operator and
//             operand B, runs an external calc stage and holds the result.
//  Revision : 1.0  initial release
// ============================================================================
module calc_seq #(
    parameter int EXEC_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [1:0] key_type,
    input  logic [3:0] key_data,
    input  logic [7:0] calc_total,
    output logic       calc_en,
    output logic [3:0] calc_in1,
    output logic [3:0] calc_in2,
    output logic [1:0] calc_ops,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       err
);

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] c_key_digit = 2'b00;
    localparam logic [1:0] c_key_op    = 2'b01;
    localparam logic [1:0] c_key_eq    = 2'b10;
    localparam logic [1:0] c_key_clr   = 2'b11;
    localparam logic [1:0] c_op_div    = 2'b11;

    // Index of the final S_EXEC cycle; the counter starts at 0 on entry.
    localparam logic [3:0] c_exec_last = 4'(EXEC_WAIT - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [1:0] r_op;
    logic [7:0] r_result;
    logic       r_result_valid;
    logic       r_err;
    logic [3:0] r_cnt;

    logic w_digit;
    logic w_oper;
    logic w_equals;
    logic w_clear;
    logic w_div0;
    logic w_exec_last;

    assign w_digit     = key_valid && (key_type == c_key_digit);
    assign w_oper      = key_valid && (key_type == c_key_op);
    assign w_equals    = key_valid && (key_type == c_key_eq);
    assign w_clear     = key_valid && (key_type == c_key_clr);
    assign w_div0      = (r_op == c_op_div) && (r_b == 4'd0);
    assign w_exec_last = (r_cnt == c_exec_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_A: begin
                if (w_clear)     w_state_next = S_A;
                else if (w_oper) w_state_next = S_B;
            end
            S_B: begin
                if (w_clear)       w_state_next = S_A;
                else if (w_equals) w_state_next = w_div0 ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                if (w_exec_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (w_clear || w_digit) w_state_next = S_A;
                else if (w_oper)        w_state_next = S_B;
            end
            default: w_state_next = S_A;
        endcase
    end

    // Operand, result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a            <= 4'd0;
            r_b            <= 4'd0;
            r_op           <= 2'd0;
            r_result       <= 8'd0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_cnt          <= 4'd0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_clear && (r_state != S_EXEC)) begin
                r_a      <= 4'd0;
                r_b      <= 4'd0;
                r_op     <= 2'd0;
                r_result <= 8'd0;
                r_err    <= 1'b0;
            end else begin
                case (r_state)
                    S_A: begin
                        if (w_digit) begin
                            r_a <= key_data;
                        end else if (w_oper) begin
                            r_op <= key_data[1:0];
                            r_b  <= 4'd0;
                        end
                    end
                    S_B: begin
                        if (w_digit) begin
                            r_b <= key_data;
                        end else if (w_oper) begin
                            r_op <= key_data[1:0];
                        end else if (w_equals) begin
                            if (w_div0) begin
                                r_err          <= 1'b1;
                                r_result       <= 8'hFF;
                                r_result_valid <= 1'b1;
                            end else begin
                                r_cnt <= 4'd0;
                            end
                        end
                    end
                    S_EXEC: begin
                        if (w_exec_last) begin
                            r_result       <= calc_total;
                            r_result_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_DONE: begin
                        if (w_digit) begin
                            r_a   <= key_data;
                            r_b   <= 4'd0;
                            r_op  <= 2'd0;
                            r_err <= 1'b0;
                        end else if (w_oper) begin
                            // Chaining keeps only the low nibble of the result.
                            r_a   <= r_result[3:0];
                            r_op  <= key_data[1:0];
                            r_b   <= 4'd0;
                            r_err <= 1'b0;
                        end
                    end
                    default: begin
                        r_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

    // Output logic
    always_comb begin
        calc_en      = (r_state == S_EXEC);
        busy         = (r_state == S_EXEC);
        calc_in1     = r_a;
        calc_in2     = r_b;
        calc_ops     = r_op;
        result       = r_result;
        result_valid = r_result_valid;
        err          = r_err;
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_seq
//  Purpose  : Self-checking bench for calc_seq; runs an EXEC_WAIT=1 and an
//             EXEC_WAIT=3 instance side by side against a calculator model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_seq;

    localparam logic [1:0] K_DIG = 2'b00;
    localparam logic [1:0] K_OP  = 2'b01;
    localparam logic [1:0] K_EQ  = 2'b10;
    localparam logic [1:0] K_CLR = 2'b11;

    localparam int M_A    = 0;
    localparam int M_B    = 1;
    localparam int M_DONE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      kv;
    logic [1:0]      kt;
    logic [3:0]      kd;
    logic [1:0]      en, busy, rv, err;
    logic [1:0][3:0] in1, in2;
    logic [1:0][1:0] ops;
    logic [1:0][7:0] res, total;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference calculator: plain 8-bit arithmetic on the two nibbles.
    function automatic logic [7:0] calc_fn(input logic [3:0] x, input logic [3:0] y,
                                           input logic [1:0] o);
        logic [7:0] xa, ya;
        xa = {4'd0, x};
        ya = {4'd0, y};
        case (o)
            2'd0:    return xa + ya;
            2'd1:    return xa - ya;
            2'd2:    return xa * ya;
            default: return (ya == 8'd0) ? 8'd0 : xa / ya;
        endcase
    endfunction

    assign total[0] = calc_fn(in1[0], in2[0], ops[0]);
    assign total[1] = calc_fn(in1[1], in2[1], ops[1]);

    calc_seq #(.EXEC_WAIT(1)) dut1 (
        .clk(clk), .rst(rst), .key_valid(kv[0]), .key_type(kt), .key_data(kd),
        .calc_total(total[0]), .calc_en(en[0]), .calc_in1(in1[0]), .calc_in2(in2[0]),
        .calc_ops(ops[0]), .result(res[0]), .result_valid(rv[0]), .busy(busy[0]),
        .err(err[0])
    );

    calc_seq #(.EXEC_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .key_valid(kv[1]), .key_type(kt), .key_data(kd),
        .calc_total(total[1]), .calc_en(en[1]), .calc_in1(in1[1]), .calc_in2(in2[1]),
        .calc_ops(ops[1]), .result(res[1]), .result_valid(rv[1]), .busy(busy[1]),
        .err(err[1])
    );

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Activity monitor, sampled 1 time unit after each rising edge.
    int         cyc = 0;
    int         en_cnt[2], busy_cnt[2], rv_cnt[2], last_en[2], rv_at[2];
    logic [9:0] cap[2];

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            en_cnt[k] = 0; busy_cnt[k] = 0; rv_cnt[k] = 0;
            last_en[k] = -10; rv_at[k] = -20; cap[k] = '0;
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (en[k] === 1'b1) begin
                en_cnt[k]++;
                last_en[k] = cyc;
                cap[k] = {in1[k], in2[k], ops[k]};
            end
            if (busy[k] === 1'b1) busy_cnt[k]++;
            if (rv[k] === 1'b1) begin
                rv_cnt[k]++;
                rv_at[k] = cyc;
            end
        end
    end

    // Behavioural calculator model
    int         m_mode;
    logic [3:0] m_a, m_b;
    logic [1:0] m_op;
    logic [7:0] m_res;
    logic       m_err;

    task automatic model_reset();
        m_mode = M_A; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_err = 0;
    endtask

    task automatic model_key(input logic [1:0] t, input logic [3:0] d,
                             output bit run, output bit div0);
        run = 0;
        div0 = 0;
        if (t == K_CLR) begin
            model_reset();
        end else begin
            case (m_mode)
                M_A: begin
                    if (t == K_DIG) m_a = d;
                    else if (t == K_OP) begin m_op = d[1:0]; m_b = 0; m_mode = M_B; end
                end
                M_B: begin
                    if (t == K_DIG) m_b = d;
                    else if (t == K_OP) m_op = d[1:0];
                    else if (t == K_EQ) begin
                        if (m_op == 2'd3 && m_b == 4'd0) begin
                            m_err = 1; m_res = 8'hFF; div0 = 1;
                        end else begin
                            m_res = calc_fn(m_a, m_b, m_op); run = 1;
                        end
                        m_mode = M_DONE;
                    end
                end
                default: begin
                    if (t == K_DIG) begin
                        m_a = d; m_b = 0; m_op = 0; m_err = 0; m_mode = M_A;
                    end else if (t == K_OP) begin
                        m_a = m_res[3:0]; m_op = d[1:0]; m_b = 0; m_err = 0; m_mode = M_B;
                    end
                end
            endcase
        end
    endtask

    // Drive one key to both instances, then leave garbage on the bus with key_valid low.
    task automatic press(input logic [1:0] t, input logic [3:0] d, input logic [1:0] mask);
        @(negedge clk);
        clear_mon();
        kt = t; kd = d; kv = mask;
        @(negedge clk);
        kv = 2'b00; kt = 2'($urandom); kd = 4'($urandom);
    endtask

    task automatic do_key(input logic [1:0] t, input logic [3:0] d,
                          output bit run, output bit div0);
        press(t, d, 2'b11);
        model_key(t, d, run, div0);
        if (run || div0) repeat (5) @(negedge clk);
    endtask

    function automatic logic [21:0] obs(input int k);
        return {in1[k], in2[k], ops[k], res[k], err[k], busy[k], en[k], rv[k]};
    endfunction

    task automatic test_reset();
        bit r, z;
        rst = 1; kv = 2'b11; kt = K_DIG; kd = 4'd9;
        repeat (2) @(negedge clk);
        rst = 0; kv = 2'b00;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs(k) !== 22'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h want 000000", k, obs(k));
            end
        end
        do_key(K_CLR, 0, r, z);
    endtask

    task automatic test_add();
        bit r, z;
        do_key(K_CLR, 0, r, z); do_key(K_DIG, 5, r, z); do_key(K_OP, 0, r, z);
        do_key(K_DIG, 7, r, z); do_key(K_EQ, 0, r, z);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (res[k] !== 8'd12 || rv_cnt[k] != 1 || en_cnt[k] != wait_of(k)
                || cap[k] !== {4'd5, 4'd7, 2'd0} || rv_at[k] != last_en[k] + 1) begin
                n_fail++;
                $display("FAIL add[%0d]: res=%0d rv=%0d en=%0d cap=%h rv_at=%0d last_en=%0d want 12/1/%0d/%h",
                         k, res[k], rv_cnt[k], en_cnt[k], cap[k], rv_at[k], last_en[k],
                         wait_of(k), {4'd5, 4'd7, 2'd0});
            end
        end
    endtask

    task automatic test_div0();
        bit r, z;
        do_key(K_CLR, 0, r, z); do_key(K_DIG, 12, r, z); do_key(K_OP, 3, r, z);
        do_key(K_DIG, 0, r, z); do_key(K_EQ, 0, r, z);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (en_cnt[k] != 0 || err[k] !== 1'b1 || res[k] !== 8'hFF || rv_cnt[k] != 1) begin
                n_fail++;
                $display("FAIL div0[%0d]: en=%0d err=%b res=%h rv=%0d want 0/1/ff/1",
                         k, en_cnt[k], err[k], res[k], rv_cnt[k]);
            end
        end
        do_key(K_DIG, 3, r, z);
        do_key(K_OP, 0, r, z);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (err[k] !== 1'b0 || in1[k] !== 4'd3) begin
                n_fail++;
                $display("FAIL div0_recover[%0d]: err=%b in1=%0d want 0/3", k, err[k], in1[k]);
            end
        end
    endtask

    task automatic test_chain();
        bit r, z;
        do_key(K_CLR, 0, r, z); do_key(K_DIG, 4, r, z); do_key(K_OP, 2, r, z);
        do_key(K_DIG, 6, r, z); do_key(K_EQ, 0, r, z);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (res[k] !== 8'd24) begin
                n_fail++;
                $display("FAIL chain_first[%0d]: res=%0d want 24", k, res[k]);
            end
        end
        do_key(K_OP, 0, r, z);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (in1[k] !== 4'd8 || in2[k] !== 4'd0 || ops[k] !== 2'd0) begin
                n_fail++;
                $display("FAIL chain_a[%0d]: in1=%0d in2=%0d ops=%0d want 8/0/0",
                         k, in1[k], in2[k], ops[k]);
            end
        end
        do_key(K_DIG, 9, r, z); do_key(K_EQ, 0, r, z);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (res[k] !== 8'd17 || rv_cnt[k] != 1) begin
                n_fail++;
                $display("FAIL chain_second[%0d]: res=%0d rv=%0d want 17/1", k, res[k], rv_cnt[k]);
            end
        end
    endtask

    task automatic test_clear_in_exec();
        bit r, z;
        do_key(K_CLR, 0, r, z); do_key(K_DIG, 8, r, z); do_key(K_OP, 1, r, z);
        do_key(K_DIG, 3, r, z);
        @(negedge clk);
        clear_mon();
        kt = K_EQ; kd = 0; kv = 2'b11;
        model_key(K_EQ, 0, r, z);
        // Clear held on the slow instance for every cycle it is executing.
        repeat (3) begin
            @(negedge clk);
            kt = K_CLR; kv = 2'b10;
        end
        @(negedge clk);
        kv = 2'b00;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy_cnt[1] != 3 || en_cnt[1] != 3 || res[1] !== 8'd5 || rv_cnt[1] != 1) begin
            n_fail++;
            $display("FAIL clear_in_exec: busy=%0d en=%0d res=%0d rv=%0d want 3/3/5/1",
                     busy_cnt[1], en_cnt[1], res[1], rv_cnt[1]);
        end
        n_tests++;
        if (res[0] !== 8'd5 || en_cnt[0] != 1) begin
            n_fail++;
            $display("FAIL clear_in_exec_fast: res=%0d en=%0d want 5/1", res[0], en_cnt[0]);
        end
    endtask

    task automatic test_rst_exec();
        bit r, z;
        do_key(K_CLR, 0, r, z); do_key(K_DIG, 1, r, z); do_key(K_OP, 0, r, z);
        do_key(K_DIG, 2, r, z);
        @(negedge clk);
        clear_mon();
        kt = K_EQ; kd = 0; kv = 2'b11;
        @(negedge clk);
        kv = 2'b00; rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs(k) !== 22'd0 || rv_cnt[k] != 0) begin
                n_fail++;
                $display("FAIL rst_exec[%0d]: got %h rv=%0d want 000000/0", k, obs(k), rv_cnt[k]);
            end
        end
        do_key(K_EQ, 0, r, z);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (en_cnt[k] != 0 || rv_cnt[k] != 0 || res[k] !== 8'd0) begin
                n_fail++;
                $display("FAIL rst_then_eq[%0d]: en=%0d rv=%0d res=%0d want 0/0/0",
                         k, en_cnt[k], rv_cnt[k], res[k]);
            end
        end
    endtask

    task automatic test_overwrite();
        bit r, z;
        do_key(K_CLR, 0, r, z); do_key(K_DIG, 9, r, z); do_key(K_DIG, 2, r, z);
        do_key(K_OP, 0, r, z); do_key(K_EQ, 0, r, z);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (cap[k] !== {4'd2, 4'd0, 2'd0} || res[k] !== 8'd2) begin
                n_fail++;
                $display("FAIL overwrite[%0d]: cap=%h res=%0d want %h/2",
                         k, cap[k], res[k], {4'd2, 4'd0, 2'd0});
            end
        end
    endtask

    task automatic test_random();
        bit         r, z;
        logic [1:0] t;
        logic [3:0] d;
        int         sel;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = $urandom_range(0, 19);
            t = (sel < 8) ? K_DIG : (sel < 13) ? K_OP : (sel < 18) ? K_EQ : K_CLR;
            d = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            do_key(t, d, r, z);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs(k) !== {m_a, m_b, m_op, m_res, m_err, 3'b000}) begin
                    n_fail++;
                    $display("FAIL random_state[%0d] i=%0d key=%0d/%0d: got %h want %h",
                             k, i, t, d, obs(k), {m_a, m_b, m_op, m_res, m_err, 3'b000});
                end
                n_tests++;
                if (en_cnt[k] != (r ? wait_of(k) : 0) || busy_cnt[k] != en_cnt[k]
                    || rv_cnt[k] != ((r || z) ? 1 : 0)
                    || (r && rv_at[k] != last_en[k] + 1)) begin
                    n_fail++;
                    $display("FAIL random_exec[%0d] i=%0d: en=%0d busy=%0d rv=%0d run=%0d div0=%0d",
                             k, i, en_cnt[k], busy_cnt[k], rv_cnt[k], r, z);
                end
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; kv = 2'b00; kt = 2'b00; kd = 4'd0;
        model_reset();
        clear_mon();
        test_reset();
        test_add();
        test_div0();
        test_chain();
        test_clear_in_exec();
        test_rst_exec();
        test_overwrite();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
